move_cmd_gen: RTL and testbench

Input-side front end for the frog game. It takes the four raw push-button lines, synchronises and debounces them, and detects presses. Each press becomes a one-command-at-a-time direction request on a valid/ready handshake, which player_control consumes. player_control then works only with clean, single-shot move commands instead of raw switch levels.

---
 rtl/move_cmd_gen_pkg.sv | 29 ++
 rtl/move_cmd_gen_sw_debounce.sv | 53 +++++
 rtl/move_cmd_gen.sv | 144 ++++++++++++++
 tb/tb_move_cmd_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/move_cmd_gen_pkg.sv
// Shared constants for the frog game input front end.
// Direction codes are also used by player_control.
package move_cmd_gen_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic {
    CMD_IDLE = 1'b0,
    CMD_PEND = 1'b1
  } cmd_state_e;

  localparam int NUM_SW = 4;

  // Fixed priority: Up > Down > Left > Right.
  function automatic dir_e prio_enc(input logic [NUM_SW-1:0] v);
    dir_e d;
    if (v[0])      d = DIR_UP;
    else if (v[1]) d = DIR_DOWN;
    else if (v[2]) d = DIR_LEFT;
    else           d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/move_cmd_gen_sw_debounce.sv
// One push-button channel: two-flop synchroniser and debouncer.
// rise_o pulses for one cycle after each debounced 0->1 flip.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic state_o,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          rise_q, rise_d;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = 1'b0;
    if (sync_q[1] == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CMAX) begin
      cnt_d   = '0;
      state_d = ~state_q;
      rise_d  = ~state_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sw_i};
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/move_cmd_gen.sv
// Button front end: debounce, priority encode, single-slot command register.
// Define MOVE_AUTOREPEAT_EN to enable hold-to-repeat moves.
module move_cmd_gen
  import move_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  output logic       MOVE_VALID,
  output logic [1:0] MOVE_DIR,
  input  logic       MOVE_READY,
  output logic [3:0] SW_STATE,
  output logic       DROPPED
);

  logic [NUM_SW-1:0] sw_raw;
  logic [NUM_SW-1:0] sw_state;
  logic [NUM_SW-1:0] sw_rise;
  logic [NUM_SW-1:0] ev_vec;
  logic              ev;
  dir_e              ev_dir;

  cmd_state_e st_q, st_d;
  dir_e       dir_q, dir_d;
  logic       drop_q, drop_d;
  logic       load;

  assign sw_raw = {SW4, SW3, SW2, SW1};

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (CLK),
      .rst_i  (RST),
      .sw_i   (sw_raw[i]),
      .state_o(sw_state[i]),
      .rise_o (sw_rise[i])
    );
  end

`ifdef MOVE_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PER = RW'(REPEAT_PERIOD);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          ract_q, ract_d;
  logic          rfirst_q, rfirst_d;
  dir_e          rown_q, rown_d;
  logic          rep_ev;

  // Counter holds cycles elapsed since the owning press or last repeat.
  assign rep_ev = ract_q && sw_state[rown_q] &&
                  (rcnt_q == (rfirst_q ? R_DLY : R_PER));
  assign ev_vec = sw_rise | ({{(NUM_SW-1){1'b0}}, rep_ev} << rown_q);

  always_comb begin
    rcnt_d   = rcnt_q;
    ract_d   = ract_q;
    rfirst_d = rfirst_q;
    rown_d   = rown_q;
    if (!sw_state[rown_q]) begin
      ract_d = 1'b0;
      rcnt_d = '0;
    end else if (ract_q) begin
      rcnt_d = rcnt_q + 1'b1;
    end
    if (rep_ev) begin
      rcnt_d   = RW'(1);
      rfirst_d = 1'b0;
    end
    if (|sw_rise) begin
      rcnt_d   = RW'(1);
      rfirst_d = 1'b1;
      if (load) begin
        rown_d = ev_dir;
        ract_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rcnt_q   <= '0;
      ract_q   <= 1'b0;
      rfirst_q <= 1'b1;
      rown_q   <= DIR_UP;
    end else begin
      rcnt_q   <= rcnt_d;
      ract_q   <= ract_d;
      rfirst_q <= rfirst_d;
      rown_q   <= rown_d;
    end
  end
`else
  assign ev_vec = sw_rise;
`endif

  assign ev     = |ev_vec;
  assign ev_dir = prio_enc(ev_vec);
  assign load   = ev && !(st_q == CMD_PEND && !MOVE_READY);

  always_comb begin
    st_d   = st_q;
    dir_d  = dir_q;
    drop_d = 1'b0;
    if (st_q == CMD_PEND && !MOVE_READY) begin
      drop_d = ev;
    end else if (ev) begin
      st_d  = CMD_PEND;
      dir_d = ev_dir;
    end else if (st_q == CMD_PEND) begin
      st_d = CMD_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= CMD_IDLE;
      dir_q  <= DIR_UP;
      drop_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      dir_q  <= dir_d;
      drop_q <= drop_d;
    end
  end

  assign MOVE_VALID = (st_q == CMD_PEND);
  assign MOVE_DIR   = dir_q;
  assign SW_STATE   = sw_state;
  assign DROPPED    = drop_q;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Scoreboard bench for move_cmd_gen with DEBOUNCE_CYCLES=4.
// Build with MOVE_AUTOREPEAT_EN to exercise the repeat timer.
module tb_move_cmd_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SW1 = 1'b0;
  logic       SW2 = 1'b0;
  logic       SW3 = 1'b0;
  logic       SW4 = 1'b0;
  logic       MOVE_READY = 1'b0;
  logic       MOVE_VALID;
  logic [1:0] MOVE_DIR;
  logic [3:0] SW_STATE;
  logic       DROPPED;

  int total = 0;
  int bad = 0;
  int drop_cnt = 0;
  int cyc = 0;
  int d0;
  logic [1:0] exp_q[$];
  int t_q[$];

  move_cmd_gen #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW1       (SW1),
    .SW2       (SW2),
    .SW3       (SW3),
    .SW4       (SW4),
    .MOVE_VALID(MOVE_VALID),
    .MOVE_DIR  (MOVE_DIR),
    .MOVE_READY(MOVE_READY),
    .SW_STATE  (SW_STATE),
    .DROPPED   (DROPPED)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every transfer is compared against the scoreboard.
  always @(negedge CLK) begin
    if (!RST && MOVE_VALID && MOVE_READY) begin
      logic [1:0] e;
      total++;
      t_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_cmd got dir=%0d, none expected", MOVE_DIR);
      end else begin
        e = exp_q.pop_front();
        if (MOVE_DIR !== e) begin
          bad++;
          $display("FAIL cmd_dir got=%0d want=%0d", MOVE_DIR, e);
        end
      end
    end
    if (!RST && DROPPED === 1'b1) drop_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, int'(MOVE_VALID), 0);
    chk({tag, "_dir"}, int'(MOVE_DIR), 0);
    chk({tag, "_swstate"}, int'(SW_STATE), 0);
    chk({tag, "_dropped"}, int'(DROPPED), 0);
  endtask

  initial begin
    step(3);
    chk_idle("in_reset");
    RST = 1'b0;
    step(3);
    chk_idle("after_reset");

`ifdef MOVE_AUTOREPEAT_EN
    MOVE_READY = 1'b1;
    SW4 = 1'b1;
    repeat (4) exp_q.push_back(2'd3);
    step(7);
    chk("rep_first_valid", int'(MOVE_VALID), 1);
    step(36);
    chk("rep_last_valid", int'(MOVE_VALID), 1);
    step(1);
    SW4 = 1'b0;
    step(30);
    chk("rep_count", t_q.size(), 4);
    if (t_q.size() == 4) begin
      chk("rep_delay", t_q[1] - t_q[0], 20);
      chk("rep_period1", t_q[2] - t_q[1], 8);
      chk("rep_period2", t_q[3] - t_q[2], 8);
    end
`else
    // Single press with READY high: VALID for one cycle on edge 7.
    MOVE_READY = 1'b1;
    SW1 = 1'b1;
    exp_q.push_back(2'd0);
    step(6);
    chk("p1_swstate", int'(SW_STATE), 1);
    chk("p1_early_valid", int'(MOVE_VALID), 0);
    step(1);
    chk("p1_valid", int'(MOVE_VALID), 1);
    chk("p1_dir", int'(MOVE_DIR), 0);
    step(1);
    chk("p1_cleared", int'(MOVE_VALID), 0);
    SW1 = 1'b0;
    step(10);
    chk("p1_released", int'(SW_STATE), 0);

    // Three-cycle glitch must be filtered.
    SW2 = 1'b1;
    step(3);
    SW2 = 1'b0;
    step(10);
    chk("glitch_swstate", int'(SW_STATE), 0);
    chk("glitch_valid", int'(MOVE_VALID), 0);

    // Simultaneous Left and Right: Left wins, no drop.
    d0 = drop_cnt;
    SW3 = 1'b1;
    SW4 = 1'b1;
    exp_q.push_back(2'd2);
    step(10);
    chk("simul_swstate", int'(SW_STATE), 4'b1100);
    chk("simul_nodrop", drop_cnt - d0, 0);
    SW3 = 1'b0;
    SW4 = 1'b0;
    step(10);

    // Pending command blocks a new press, which is dropped.
    MOVE_READY = 1'b0;
    SW2 = 1'b1;
    exp_q.push_back(2'd1);
    step(7);
    chk("pend_valid", int'(MOVE_VALID), 1);
    chk("pend_dir", int'(MOVE_DIR), 1);
    d0 = drop_cnt;
    SW4 = 1'b1;
    step(9);
    chk("drop_dir_kept", int'(MOVE_DIR), 1);
    chk("drop_valid_kept", int'(MOVE_VALID), 1);
    chk("drop_pulses", drop_cnt - d0, 1);
    chk("drop_swstate", int'(SW_STATE), 4'b1010);
    MOVE_READY = 1'b1;
    step(1);
    MOVE_READY = 1'b0;
    chk("accept_cleared", int'(MOVE_VALID), 0);
    SW2 = 1'b0;
    SW4 = 1'b0;
    step(10);

    // Accept in the same cycle as a new press: reload, no drop.
    SW2 = 1'b1;
    exp_q.push_back(2'd1);
    step(7);
    chk("acc_pend_dir", int'(MOVE_DIR), 1);
    d0 = drop_cnt;
    SW1 = 1'b1;
    exp_q.push_back(2'd0);
    step(6);
    MOVE_READY = 1'b1;
    step(1);
    chk("acc_reload_valid", int'(MOVE_VALID), 1);
    chk("acc_reload_dir", int'(MOVE_DIR), 0);
    step(1);
    chk("acc_reload_cleared", int'(MOVE_VALID), 0);
    chk("acc_nodrop", drop_cnt - d0, 0);
    SW1 = 1'b0;
    SW2 = 1'b0;
    step(10);

    // Asynchronous reset while pending, switch held through release.
    MOVE_READY = 1'b0;
    SW3 = 1'b1;
    step(7);
    chk("rst_pend_valid", int'(MOVE_VALID), 1);
    RST = 1'b1;
    #1;
    chk("rst_async_valid", int'(MOVE_VALID), 0);
    chk("rst_async_swstate", int'(SW_STATE), 0);
    step(2);
    RST = 1'b0;
    MOVE_READY = 1'b1;
    exp_q.push_back(2'd2);
    step(12);
    chk("held_swstate", int'(SW_STATE), 4'b0100);
    SW3 = 1'b0;
    step(10);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
